// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, opcodes, selects.
// No logic of its own; constants and one helper function only.
// No flow control; consumers decode these combinationally.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_IF      = 4'd1,
        S_ID      = 4'd2,
        S_EX_R    = 4'd3,
        S_EX_I    = 4'd4,
        S_WB_ALU  = 4'd5,
        S_EX_ADDR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_WB_LD   = 4'd8,
        S_MEM_WR  = 4'd9,
        S_LUI     = 4'd10,
        S_EX_BR   = 4'd11,
        S_JAL     = 4'd12,
        S_HALT    = 4'd13,
        S_ERR     = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_I      = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_LUI    = 4'd4,
        CL_BRANCH = 4'd5,
        CL_JAL    = 4'd6,
        CL_SYSTEM = 4'd7,
        CL_ILL    = 4'd8
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_IMM = 2'b01;
    localparam logic [1:0] WD_MEM = 2'b10;
    localparam logic [1:0] WD_PC4 = 2'b11;

    localparam logic [1:0] PCS_PC4     = 2'b00;
    localparam logic [1:0] PCS_PC0_IMM = 2'b01;
    localparam logic [1:0] PCS_RS1_IMM = 2'b10;

    // Only beq/bne are resolved; every other branch funct3 falls through.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Opcode decode: maps IR[6:0] to the state that follows S_ID and an instruction class.
// Latency: purely combinational, zero cycles.
// No backpressure; the IR holds the opcode stable for the whole instruction.
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic [6:0] opcode,
    output state_t     id_next,
    output iclass_t    iclass
);

    // Opcode lookup; unknown opcodes either park in S_ERR or are skipped.
    always_comb begin
        id_next = ERR_STICKY ? S_ERR : S_IF;
        iclass  = CL_ILL;
        case (opcode)
            OP_R:      begin id_next = S_EX_R;    iclass = CL_R;      end
            OP_I:      begin id_next = S_EX_I;    iclass = CL_I;      end
            OP_LOAD:   begin id_next = S_EX_ADDR; iclass = CL_LOAD;   end
            OP_STORE:  begin id_next = S_EX_ADDR; iclass = CL_STORE;  end
            OP_LUI:    begin id_next = S_LUI;     iclass = CL_LUI;    end
            OP_BRANCH: begin id_next = S_EX_BR;   iclass = CL_BRANCH; end
            OP_JAL:    begin id_next = S_JAL;     iclass = CL_JAL;    end
            OP_SYSTEM: begin id_next = S_HALT;    iclass = CL_SYSTEM; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Moore control FSM walking RV32I instructions through IF/ID/EX/MEM/WB.
// Latency: 3-5 cycles per instruction (lui/branch/jal 3, ALU/sw 4, lw 5).
// No backpressure; run only gates leaving S_IDLE, HALT/ERR hold until reset.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_TO_IDLE = 1'b1,
    parameter bit ERR_STICKY    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zf,
    output logic       PC_Write,
    output logic       PC0_Write,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic       Mem_Write,
    output logic       rs2_imm_s,
    output logic [1:0] w_data_s,
    output logic [1:0] PC_s,
    output logic [3:0] ALU_OP,
    output logic       halted,
    output logic       err,
    output logic [3:0] state
);

    localparam state_t RST_STATE = RESET_TO_IDLE ? S_IDLE : S_IF;

    state_t     state_q;
    state_t     state_d;
    state_t     id_next;
    iclass_t    iclass;

    logic       pc_write_d;
    logic       pc0_write_d;
    logic       ir_write_d;
    logic       reg_write_d;
    logic       mem_write_d;
    logic       rs2_imm_s_d;
    logic [1:0] w_data_s_d;
    logic [1:0] pc_s_d;
    logic [3:0] alu_op_d;
    logic       halted_d;
    logic       err_d;

    rv_ctrl_decode #(
        .ERR_STICKY (ERR_STICKY)
    ) u_decode (
        .opcode  (opcode),
        .id_next (id_next),
        .iclass  (iclass)
    );

    // State register; an asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing per instruction class.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run) state_d = S_IF;
            S_IF:      state_d = S_ID;
            S_ID:      state_d = id_next;
            S_EX_R:    state_d = S_WB_ALU;
            S_EX_I:    state_d = S_WB_ALU;
            S_WB_ALU:  state_d = S_IF;
            S_EX_ADDR: state_d = (iclass == CL_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = S_WB_LD;
            S_WB_LD:   state_d = S_IF;
            S_MEM_WR:  state_d = S_IF;
            S_LUI:     state_d = S_IF;
            S_EX_BR:   state_d = S_IF;
            S_JAL:     state_d = S_IF;
            S_HALT:    state_d = S_HALT;
            S_ERR:     state_d = S_ERR;
            default:   state_d = RST_STATE;
        endcase
    end

    // Moore output decode; only branch PC_Write (zf) and ALU_OP (IR fields) look past the state.
    always_comb begin
        pc_write_d  = 1'b0;
        pc0_write_d = 1'b0;
        ir_write_d  = 1'b0;
        reg_write_d = 1'b0;
        mem_write_d = 1'b0;
        rs2_imm_s_d = 1'b0;
        w_data_s_d  = WD_ALU;
        pc_s_d      = PCS_PC4;
        alu_op_d    = ALU_ADD;
        halted_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IF: begin
                ir_write_d  = 1'b1;
                pc_write_d  = 1'b1;
                pc0_write_d = 1'b1;
                pc_s_d      = PCS_PC4;
            end
            S_EX_R: begin
                rs2_imm_s_d = 1'b0;
                alu_op_d    = {funct7_5, funct3};
            end
            S_EX_I: begin
                // IR[30] is an immediate bit except on shift-right, where it picks srai.
                rs2_imm_s_d = 1'b1;
                alu_op_d    = (funct3 == F3_SRX) ? {funct7_5, funct3} : {1'b0, funct3};
            end
            S_WB_ALU: begin
                reg_write_d = 1'b1;
                w_data_s_d  = WD_ALU;
            end
            S_EX_ADDR: begin
                rs2_imm_s_d = 1'b1;
                alu_op_d    = ALU_ADD;
            end
            S_WB_LD: begin
                reg_write_d = 1'b1;
                w_data_s_d  = WD_MEM;
            end
            S_MEM_WR: begin
                mem_write_d = 1'b1;
            end
            S_LUI: begin
                reg_write_d = 1'b1;
                w_data_s_d  = WD_IMM;
            end
            S_EX_BR: begin
                rs2_imm_s_d = 1'b0;
                alu_op_d    = ALU_SUB;
                pc_s_d      = PCS_PC0_IMM;
                pc_write_d  = branch_taken(funct3, zf);
            end
            S_JAL: begin
                reg_write_d = 1'b1;
                w_data_s_d  = WD_PC4;
                pc_write_d  = 1'b1;
                pc_s_d      = PCS_PC0_IMM;
            end
            S_HALT: halted_d = 1'b1;
            S_ERR:  err_d    = 1'b1;
            default: ;
        endcase
    end

    // Outputs are forced quiet while reset is held, even when reset parks the FSM in S_IF.
    assign PC_Write  = rst_n & pc_write_d;
    assign PC0_Write = rst_n & pc0_write_d;
    assign IR_Write  = rst_n & ir_write_d;
    assign Reg_Write = rst_n & reg_write_d;
    assign Mem_Write = rst_n & mem_write_d;
    assign rs2_imm_s = rst_n & rs2_imm_s_d;
    assign w_data_s  = rst_n ? w_data_s_d : 2'b00;
    assign PC_s      = rst_n ? pc_s_d     : 2'b00;
    assign ALU_OP    = rst_n ? alu_op_d   : 4'b0000;
    assign halted    = rst_n & halted_d;
    assign err       = rst_n & err_d;
    assign state     = state_q;

endmodule
